// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command controller: default widths,
// command-word field positions and the controller state encoding.
package spi_pkg;

    localparam int SPI_N_BITS    = 8;
    localparam int SPI_ADDR_BITS = 6;

    // Start address sits in the low bits of the command word.
    localparam int CMD_ADDR_LSB  = 0;

    // The read/write flag is always the MSB of the command word.
    function automatic int cmd_rw_bit(input int n_bits);
        return n_bits - 1;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CMD      = 3'd1,
        ST_WRITE    = 3'd2,
        ST_RD_FETCH = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_RD_HOLD  = 3'd5
    } spi_state_t;

endpackage

// File: rtl/spi_cmd_ctrl.sv
// SPI command controller: decodes the first byte of a frame as a
// read/write command with a start address, then streams register writes
// (MOSI bytes) or register reads (MISO bytes) with auto-incrementing
// address. Pure control; sits beside the byte shifter.
//
// Handshakes: din_valid is a one-cycle pulse per received byte. dout is
// offered while dout_valid is high; the shifter takes it by pulsing
// dout_ack, which drops dout_valid on the next edge. An ack with
// dout_valid low is an underrun. reg_rdata is valid one cycle after reg_re.
module spi_cmd_ctrl
    import spi_pkg::*;
#(
    parameter int N_BITS    = SPI_N_BITS,
    parameter int ADDR_BITS = SPI_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cs_n,
    input  logic [N_BITS-1:0]    din,
    input  logic                 din_valid,
    output logic [N_BITS-1:0]    dout,
    output logic                 dout_valid,
    input  logic                 dout_ack,
    output logic [ADDR_BITS-1:0] reg_addr,
    output logic [N_BITS-1:0]    reg_wdata,
    output logic                 reg_we,
    output logic                 reg_re,
    input  logic [N_BITS-1:0]    reg_rdata,
    output logic                 frame_done,
    output logic                 underrun,
    input  logic                 underrun_clr,
    output spi_state_t           dbg_state
);

    localparam int RW_BIT = cmd_rw_bit(N_BITS);

    spi_state_t          r_state;
    spi_state_t          w_state_next;
    logic                r_armed;
    logic                r_cmd_seen;
    logic [ADDR_BITS-1:0] r_addr;
    logic [N_BITS-1:0]   r_wdata;
    logic                r_we;
    logic [N_BITS-1:0]   r_dout;
    logic                r_dout_valid;
    logic                r_frame_done;
    logic                r_underrun;

    logic                w_reg_re;
    logic                w_cmd_take;
    logic                w_wr_take;
    logic                w_rd_load;
    logic                w_rd_ack;
    logic                w_ur_set;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic; chip select high always returns to IDLE.
    always_comb begin
        w_state_next = r_state;
        if (cs_n) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:     if (r_armed) w_state_next = ST_CMD;
                ST_CMD:      if (din_valid)
                                 w_state_next = din[RW_BIT] ? ST_RD_FETCH : ST_WRITE;
                ST_WRITE:    w_state_next = ST_WRITE;
                ST_RD_FETCH: w_state_next = ST_RD_WAIT;
                ST_RD_WAIT:  w_state_next = ST_RD_HOLD;
                ST_RD_HOLD:  if (dout_ack) w_state_next = ST_RD_FETCH;
                default:     w_state_next = ST_IDLE;
            endcase
        end
    end

    // Per-state control strobes driving the datapath registers.
    always_comb begin
        w_reg_re   = (r_state == ST_RD_FETCH);
        w_cmd_take = (r_state == ST_CMD)     && din_valid && !cs_n;
        w_wr_take  = (r_state == ST_WRITE)   && din_valid && !cs_n;
        w_rd_load  = (r_state == ST_RD_WAIT) && !cs_n;
        w_rd_ack   = (r_state == ST_RD_HOLD) && dout_ack && !cs_n;
        w_ur_set   = dout_ack && !r_dout_valid;
    end

    // Frames only start once cs_n has been seen high since reset, so a
    // reset released mid-frame does not decode the tail of that frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_armed <= 1'b0;
        else        r_armed <= r_armed | cs_n;
    end

    // Address: loaded by the command byte, bumped after each write strobe
    // and after each consumed read byte; wraps naturally at the width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_addr <= '0;
        else if (w_cmd_take)       r_addr <= din[CMD_ADDR_LSB +: ADDR_BITS];
        else if (r_we || w_rd_ack) r_addr <= r_addr + ADDR_BITS'(1);
    end

    // Register write strobe and data, one cycle per received data byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_we <= w_wr_take;
            if (w_wr_take) r_wdata <= din;
        end
    end

    // MISO byte: loaded from the register file, cleared on ack or frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (cs_n || w_rd_ack) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (w_rd_load) begin
            r_dout       <= reg_rdata;
            r_dout_valid <= 1'b1;
        end
    end

    // Frame-end pulse, only for frames that delivered a command byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_seen   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= cs_n && r_cmd_seen;
            if (cs_n)            r_cmd_seen <= 1'b0;
            else if (w_cmd_take) r_cmd_seen <= 1'b1;
        end
    end

    // Sticky underrun; a new underrun wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_underrun <= 1'b0;
        else        r_underrun <= w_ur_set | (r_underrun & ~underrun_clr);
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign reg_addr   = r_addr;
    assign reg_wdata  = r_wdata;
    assign reg_we     = r_we;
    assign reg_re     = w_reg_re;
    assign frame_done = r_frame_done;
    assign underrun   = r_underrun;
    assign dbg_state  = r_state;

endmodule
